// File: rtl/alu.sv
// ALU: single-cycle 32-bit arithmetic/logic/shift unit with registered result and
// {Z,C,N,V} flags. The operation is decoded combinationally and lands in the
// output registers on the next rising clock edge.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    input  logic [4:0]  uop,
    output logic [31:0] out_alu,
    output logic [3:0]  flags_out
);

    typedef enum logic [4:0] {
        OpNop = 5'd0,
        OpAdd = 5'd1,
        OpSub = 5'd2,
        OpAnd = 5'd3,
        OpXor = 5'd4,
        OpCmp = 5'd5,
        OpLsl = 5'd6,
        OpLsr = 5'd7,
        OpMov = 5'd8,
        OpOrr = 5'd9,
        OpBic = 5'd10,
        OpMvn = 5'd11,
        OpAsr = 5'd12,
        OpRor = 5'd13,
        OpAdc = 5'd14,
        OpSbc = 5'd15,
        OpTst = 5'd16
    } aluOp_e;

    logic [31:0] outAlu_q, outAlu_d;
    logic [3:0]  flags_q, flags_d;

    logic        carryFlag;
    logic        isSubtract;
    logic [31:0] addOperandB;
    logic        addCarryIn;
    logic [32:0] addSum;
    logic        addOverflow;

    logic [7:0]  shiftAmt;
    logic [4:0]  rotAmt;
    logic [32:0] lslWide;
    logic [32:0] lsrWide;
    logic [32:0] asrWide;
    logic [31:0] rorResult;

    logic [31:0] result;
    logic        newCarry;
    logic        newOverflow;
    logic        writeResult;
    logic        writeFlags;

    assign carryFlag = flags_q[2];
    assign shiftAmt  = rhs[7:0];
    assign rotAmt    = rhs[4:0];

    // Shared adder: subtraction is lhs + ~rhs + carry-in, so the carry out doubles as "no borrow".
    always_comb begin
        isSubtract  = (uop == OpSub) || (uop == OpCmp) || (uop == OpSbc);
        addOperandB = isSubtract ? ~rhs : rhs;
        if (uop == OpAdd) begin
            addCarryIn = 1'b0;
        end else if ((uop == OpSub) || (uop == OpCmp)) begin
            addCarryIn = 1'b1;
        end else begin
            addCarryIn = carryFlag;
        end
        addSum      = {1'b0, lhs} + {1'b0, addOperandB} + {32'd0, addCarryIn};
        addOverflow = (lhs[31] == addOperandB[31]) && (addSum[31] != lhs[31]);
    end

    // Shifters carry one guard bit so the last bit shifted out falls out naturally for any amount.
    always_comb begin
        lslWide   = {1'b0, lhs} << shiftAmt;
        lsrWide   = {lhs, 1'b0} >> shiftAmt;
        asrWide   = $signed({lhs, 1'b0}) >>> shiftAmt;
        rorResult = (lhs >> rotAmt) | (lhs << (6'd32 - {1'b0, rotAmt}));
    end

    // Operation decode: pick the result, the new C/V, and which registers this op updates.
    always_comb begin
        result      = outAlu_q;
        newCarry    = flags_q[2];
        newOverflow = flags_q[0];
        writeResult = 1'b0;
        writeFlags  = 1'b0;
        case (uop)
            OpAdd, OpSub, OpAdc, OpSbc: begin
                result      = addSum[31:0];
                newCarry    = addSum[32];
                newOverflow = addOverflow;
                writeResult = 1'b1;
                writeFlags  = 1'b1;
            end
            OpCmp: begin
                result      = addSum[31:0];
                newCarry    = addSum[32];
                newOverflow = addOverflow;
                writeFlags  = 1'b1;
            end
            OpAnd: begin
                result      = lhs & rhs;
                writeResult = 1'b1;
                writeFlags  = 1'b1;
            end
            OpXor: begin
                result      = lhs ^ rhs;
                writeResult = 1'b1;
                writeFlags  = 1'b1;
            end
            OpOrr: begin
                result      = lhs | rhs;
                writeResult = 1'b1;
                writeFlags  = 1'b1;
            end
            OpBic: begin
                result      = lhs & ~rhs;
                writeResult = 1'b1;
                writeFlags  = 1'b1;
            end
            OpMov: begin
                result      = rhs;
                writeResult = 1'b1;
                writeFlags  = 1'b1;
            end
            OpMvn: begin
                result      = ~rhs;
                writeResult = 1'b1;
                writeFlags  = 1'b1;
            end
            OpTst: begin
                result      = lhs & rhs;
                writeFlags  = 1'b1;
            end
            OpLsl: begin
                result = lhs;
                if (shiftAmt != 8'd0) begin
                    result   = lslWide[31:0];
                    newCarry = lslWide[32];
                end
                writeResult = 1'b1;
                writeFlags  = 1'b1;
            end
            OpLsr: begin
                result = lhs;
                if (shiftAmt != 8'd0) begin
                    result   = lsrWide[32:1];
                    newCarry = lsrWide[0];
                end
                writeResult = 1'b1;
                writeFlags  = 1'b1;
            end
            OpAsr: begin
                result = lhs;
                if (shiftAmt != 8'd0) begin
                    result   = asrWide[32:1];
                    newCarry = asrWide[0];
                end
                writeResult = 1'b1;
                writeFlags  = 1'b1;
            end
            OpRor: begin
                result = lhs;
                if (shiftAmt != 8'd0) begin
                    result   = rorResult;
                    newCarry = rorResult[31];
                end
                writeResult = 1'b1;
                writeFlags  = 1'b1;
            end
            default: begin
            end
        endcase
        outAlu_d = writeResult ? result : outAlu_q;
        flags_d  = writeFlags ? {(result == 32'd0), newCarry, result[31], newOverflow} : flags_q;
    end

    // Output registers with synchronous reset that discards the op presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            outAlu_q <= 32'd0;
            flags_q  <= 4'b0000;
        end else begin
            outAlu_q <= outAlu_d;
            flags_q  <= flags_d;
        end
    end

    assign out_alu   = outAlu_q;
    assign flags_out = flags_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard testbench for alu: each driven op pushes its expected {flags,result}
// from a behavioural model, and the entry is popped and compared after the edge.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [4:0]  uop;
    logic [31:0] out_alu;
    logic [3:0]  flags_out;

    int          checkCount;
    int          errorCount;
    logic [35:0] expQ[$];
    logic [31:0] modelOut;
    logic [3:0]  modelFlags;

    alu dut (
        .clk       (clk),
        .rst       (rst),
        .lhs       (lhs),
        .rhs       (rhs),
        .uop       (uop),
        .out_alu   (out_alu),
        .flags_out (flags_out)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", tag, observed, expected);
        end
    endtask

    // Behavioural reference: arithmetic in 64-bit integers, shifts done one bit at a time.
    function automatic logic [35:0] modelOp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] prevOut, input logic [3:0] prevFlags);
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        keepOut;
        longint      ua;
        longint      ub;
        longint      us;
        longint      ss;
        int          amt;
        int          borrow;
        c       = prevFlags[2];
        v       = prevFlags[0];
        r       = 32'd0;
        keepOut = 1'b0;
        ua      = longint'({32'd0, a});
        ub      = longint'({32'd0, b});
        amt     = int'(b[7:0]);
        if (op == 5'd0 || op > 5'd16) begin
            return {prevFlags, prevOut};
        end
        case (op)
            5'd1, 5'd14: begin
                borrow = (op == 5'd14 && prevFlags[2]) ? 1 : 0;
                us = ua + ub + longint'(borrow);
                ss = longint'($signed(a)) + longint'($signed(b)) + longint'(borrow);
                r  = us[31:0];
                c  = (us > 64'sh0FFFFFFFF);
                v  = (ss > 64'sh7FFFFFFF) || (ss < -64'sh80000000);
            end
            5'd2, 5'd5, 5'd15: begin
                borrow = (op == 5'd15 && !prevFlags[2]) ? 1 : 0;
                us = ua - ub - longint'(borrow);
                ss = longint'($signed(a)) - longint'($signed(b)) - longint'(borrow);
                r  = us[31:0];
                c  = (us >= 0);
                v  = (ss > 64'sh7FFFFFFF) || (ss < -64'sh80000000);
                keepOut = (op == 5'd5);
            end
            5'd3:  r = a & b;
            5'd4:  r = a ^ b;
            5'd8:  r = b;
            5'd9:  r = a | b;
            5'd10: r = a & ~b;
            5'd11: r = ~b;
            5'd16: begin
                r = a & b;
                keepOut = 1'b1;
            end
            5'd6: begin
                r = a;
                for (int i = 0; i < amt; i++) begin
                    c = r[31];
                    r = {r[30:0], 1'b0};
                end
            end
            5'd7: begin
                r = a;
                for (int i = 0; i < amt; i++) begin
                    c = r[0];
                    r = {1'b0, r[31:1]};
                end
            end
            5'd12: begin
                r = a;
                for (int i = 0; i < amt; i++) begin
                    c = r[0];
                    r = {r[31], r[31:1]};
                end
            end
            5'd13: begin
                r = a;
                for (int i = 0; i < (amt % 32); i++) begin
                    r = {r[0], r[31:1]};
                end
                if (amt != 0) c = r[31];
            end
            default: r = prevOut;
        endcase
        return {(r == 32'd0), c, r[31], v, (keepOut ? prevOut : r)};
    endfunction

    // Drive one op at the falling edge, push its expectation, then pop and compare after the rising edge.
    task automatic applyStimulus(input string tag, input logic rstVal, input logic [4:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        logic [35:0] expected;
        logic [35:0] popped;
        @(negedge clk);
        rst = rstVal;
        uop = op;
        lhs = a;
        rhs = b;
        if (rstVal) begin
            expected = 36'd0;
        end else begin
            expected = modelOp(op, a, b, modelOut, modelFlags);
        end
        modelOut   = expected[31:0];
        modelFlags = expected[35:32];
        expQ.push_back(expected);
        @(posedge clk);
        #1;
        popped = expQ.pop_front();
        checkOutput({tag, "_out"}, out_alu, popped[31:0]);
        checkOutput({tag, "_flags"}, {28'd0, flags_out}, {28'd0, popped[35:32]});
    endtask

    initial begin
        logic [4:0]  rOp;
        logic [31:0] rA;
        logic [31:0] rB;
        checkCount = 0;
        errorCount = 0;
        modelOut   = 32'd0;
        modelFlags = 4'd0;
        rst = 1'b1;
        uop = 5'd0;
        lhs = 32'd0;
        rhs = 32'd0;

        applyStimulus("reset", 1'b1, 5'd1, 32'h1, 32'h2);
        applyStimulus("nop0", 1'b0, 5'd0, 32'h0, 32'h1);
        checkOutput("nop0_const", out_alu, 32'h0);

        applyStimulus("add01", 1'b0, 5'd1, 32'h0, 32'h1);
        checkOutput("add01_const", {28'd0, flags_out}, 32'h0);
        applyStimulus("sub11", 1'b0, 5'd2, 32'h1, 32'h1);
        checkOutput("sub11_const", {28'd0, flags_out}, 32'hC);
        applyStimulus("and", 1'b0, 5'd3, 32'hF0F0F0F0, 32'h0F0F0F0F);
        checkOutput("and_const", {28'd0, flags_out}, 32'hC);
        applyStimulus("xor", 1'b0, 5'd4, 32'hAAAAAAAA, 32'h55555555);
        checkOutput("xor_const", {28'd0, flags_out}, 32'h6);
        applyStimulus("cmp", 1'b0, 5'd5, 32'h7FFFFFFF, 32'hFFFFFFFF);
        checkOutput("cmp_const_out", out_alu, 32'hFFFFFFFF);
        checkOutput("cmp_const_flags", {28'd0, flags_out}, 32'h3);
        applyStimulus("lsl1", 1'b0, 5'd6, 32'h00000001, 32'd1);
        checkOutput("lsl1_const", out_alu, 32'h2);
        applyStimulus("lsr1", 1'b0, 5'd7, 32'h80000000, 32'd1);
        checkOutput("lsr1_const", out_alu, 32'h40000000);
        applyStimulus("lslTop", 1'b0, 5'd6, 32'h80000000, 32'd1);
        checkOutput("lslTop_const", {28'd0, flags_out}, 32'hD);
        applyStimulus("mov", 1'b0, 5'd8, 32'h0, 32'h12345678);
        checkOutput("mov_const", out_alu, 32'h12345678);
        applyStimulus("rstAdd", 1'b1, 5'd1, 32'h5, 32'h6);
        checkOutput("rstAdd_const", {28'd0, flags_out}, 32'h0);

        // Boundary cases: wide shifts, zero shift, rotate by a multiple of 32, carry chains, unused opcodes.
        applyStimulus("addWrap", 1'b0, 5'd1, 32'hFFFFFFFF, 32'h1);
        applyStimulus("adcC", 1'b0, 5'd14, 32'h7FFFFFFF, 32'h0);
        applyStimulus("sbcC1", 1'b0, 5'd15, 32'h5, 32'h5);
        applyStimulus("sbcC0", 1'b0, 5'd15, 32'h5, 32'h5);
        applyStimulus("lsl32", 1'b0, 5'd6, 32'h00000003, 32'd32);
        applyStimulus("lsl0", 1'b0, 5'd6, 32'h80000001, 32'h00000100);
        applyStimulus("lsr32", 1'b0, 5'd7, 32'h80000000, 32'd32);
        applyStimulus("lsr33", 1'b0, 5'd7, 32'hFFFFFFFF, 32'd33);
        applyStimulus("asr40", 1'b0, 5'd12, 32'h80000000, 32'd40);
        applyStimulus("asr4", 1'b0, 5'd12, 32'h80000010, 32'd4);
        applyStimulus("ror8", 1'b0, 5'd13, 32'h000000F1, 32'd8);
        applyStimulus("ror32", 1'b0, 5'd13, 32'h80000000, 32'd32);
        applyStimulus("bic", 1'b0, 5'd10, 32'hFFFF0000, 32'hF0F0F0F0);
        applyStimulus("mvn", 1'b0, 5'd11, 32'h0, 32'hFFFFFFFF);
        applyStimulus("orr", 1'b0, 5'd9, 32'h00F00000, 32'h0000000F);
        applyStimulus("tst", 1'b0, 5'd16, 32'h0000FF00, 32'h000000FF);
        applyStimulus("op17", 1'b0, 5'd17, 32'h1, 32'h1);
        applyStimulus("op31", 1'b0, 5'd31, 32'hFFFFFFFF, 32'h0);

        // Random ops, with shift amounts kept near the interesting 0..40 range.
        for (int i = 0; i < 120; i++) begin
            rOp = 5'($urandom_range(0, 31));
            rA  = $urandom;
            rB  = $urandom;
            if (rOp == 5'd6 || rOp == 5'd7 || rOp == 5'd12 || rOp == 5'd13) begin
                rB = (rB & 32'hFFFFFF00) | 32'($urandom_range(0, 40));
            end
            applyStimulus("rand", 1'b0, rOp, rA, rB);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1 (single clock, rising edge); rst in 1 (reset, synchronous, active-high); lhs in 32 (first operand); rhs in 32 (second operand or shift amount); uop in 5 (operation select); out_alu out 32 (registered result); flags_out out 4 (registered flags {Z,C,N,V}: [3]=Z, [2]=C, [1]=N, [0]=V).
REQ-002 SHALL have no parameters.

Function
REQ-003 SHALL compute the result and new flags combinationally from lhs, rhs, uop and the current flags_out, and load them into out_alu/flags_out on the rising clk edge: latency 1 cycle, throughput 1 op/cycle, no handshake.
REQ-004 SHALL decode uop: 0 NOP; 1 ADD lhs+rhs; 2 SUB lhs-rhs; 3 AND; 4 XOR; 5 CMP lhs-rhs; 6 LSL lhs<<amt; 7 LSR lhs>>amt; 8 MOV rhs; 9 ORR; 10 BIC lhs&~rhs; 11 MVN ~rhs; 12 ASR (arithmetic); 13 ROR; 14 ADC lhs+rhs+C; 15 SBC lhs-rhs-(1-C); 16 TST lhs&rhs.
REQ-005 SHALL treat uop 17-31 exactly as NOP.
REQ-006 NOP SHALL hold out_alu and flags_out unchanged.
REQ-007 CMP and TST SHALL update flags only; out_alu holds its previous value.
REQ-008 ADD/ADC: 33-bit sum; C = bit 32; V = operands same sign and result sign differs.
REQ-009 SUB/CMP/SBC: computed as lhs + ~rhs + carry-in (1 for SUB/CMP, C for SBC); C = carry out (1 = no borrow, i.e. lhs >= rhs unsigned for SUB/CMP); V = operand signs differ and result sign differs from lhs.
REQ-010 Arithmetic ops SHALL wrap modulo 2^32.
REQ-011 All ops except NOP SHALL set Z = (result==0) and N = result[31]; for CMP/TST "result" is the discarded value.
REQ-012 Logical ops (AND, XOR, ORR, BIC, MVN, MOV, TST) SHALL leave C and V unchanged.
REQ-013 Shifts SHALL use amt = rhs[7:0]; V unchanged; C = last bit shifted out.
REQ-014 Shift amt 0 SHALL give result = lhs with C unchanged.
REQ-015 LSL/LSR amt 32 SHALL give result 0, with C = lhs[0] (LSL) or lhs[31] (LSR); amt > 32 SHALL give result 0 and C = 0.
REQ-016 ASR amt >= 32 SHALL give all bits = lhs[31] and C = lhs[31].
REQ-017 ROR SHALL use amt[4:0] for the rotation and set C = result[31]; amt[4:0]==0 with amt != 0 SHALL give result lhs and C = lhs[31].

Reset
REQ-018 When rst is high at a rising clk edge, out_alu SHALL load 0x00000000 and flags_out SHALL load 4'b0000, overriding uop.
REQ-019 Between reset and the first clk edge, outputs SHALL be undefined only if no edge has yet occurred; there SHALL be no asynchronous path from rst.
REQ-020 Reset SHALL take effect on the cycle it is sampled; an operation presented in that cycle SHALL be lost.

Verification
REQ-021 Reset, then NOP with lhs=0, rhs=1 -> out_alu=0x00000000, flags=0000.
REQ-022 ADD 0+1 -> out_alu=0x00000001, flags Z0 C0 N0 V0; then SUB 1-1 -> out_alu=0, Z1 C1 N0 V0.
REQ-023 AND 0xF0F0F0F0 & 0x0F0F0F0F -> 0, Z=1, N=0; XOR 0xAAAAAAAA ^ 0x55555555 -> 0xFFFFFFFF, Z=0, N=1; C and V unchanged for both.
REQ-024 CMP 0x7FFFFFFF vs 0xFFFFFFFF -> out_alu unchanged, Z0 C0 N1 V1.
REQ-025 LSL 0x00000001 by 1 -> 0x00000002, C=0; LSR 0x80000000 by 1 -> 0x40000000, C=0; LSL 0x80000000 by 1 -> 0, Z=1, C=1.
REQ-026 MOV rhs=0x12345678 -> out_alu=0x12345678, Z0 N0; then assert rst for one edge with ADD presented -> out_alu=0, flags=0000.
